// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller.
//   intc_state_e : controller FSM state, encoding is visible in CONTROL readback
//   PENDING/ENABLE/VECTOR/CONTROL : register select addresses
package intc_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } intc_state_e;

    localparam logic [1:0] PENDING = 2'b00;
    localparam logic [1:0] ENABLE  = 2'b01;
    localparam logic [1:0] VECTOR  = 2'b10;
    localparam logic [1:0] CONTROL = 2'b11;

    localparam int unsigned VectorW = 5;
    localparam int unsigned DataW   = 32;

endpackage

// File: rtl/prio_encoder.sv
// Lowest-set-bit priority encoder.
//   vec_i   : request vector
//   idx_o   : index of the lowest set bit (0 when none set)
//   valid_o : 1 when any bit of vec_i is set
module prio_encoder #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] vec_i,
    output logic [4:0]       idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = 5'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller with a single, non-nesting service slot.
//   clk, rst_n        : clock, synchronous active-low reset
//   irq               : level sources, rising edges latch into PENDING
//   data              : 32-bit register bus, driven only while rd=1
//   reg_sel, rd, wr   : register select, combinational read, clocked write
//   int_req           : request to CPU (high only in REQ state)
//   int_vector        : index of requested source, held outside REQ
//   int_ack           : CPU acknowledge, honoured only in REQ
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    inout  wire  [DataW-1:0]   data,
    input  logic [1:0]         reg_sel,
    input  logic               rd,
    input  logic               wr,
    output logic               int_req,
    output logic [VectorW-1:0] int_vector,
    input  logic               int_ack
);

    intc_state_e        state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic               gen_q, gen_d;
    logic               in_service_q, in_service_d;
    logic [VectorW-1:0] vector_q, vector_d;

    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] vec_mask;
    logic [VectorW-1:0] win_idx;
    logic               win_valid;
    logic               wr_pending, wr_enable, wr_control;
    logic               eoi, ack_take;
    logic [DataW-1:0]   rdata;
    logic               unused_data;

    assign unused_data = ^data;

    prio_encoder #(
        .Width (NUM_IRQ)
    ) u_prio (
        .vec_i   (pending_q & enable_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign irq_edge   = irq & ~irq_q;
    assign vec_mask   = NUM_IRQ'(1) << vector_q;
    assign wr_pending = wr && (reg_sel == PENDING);
    assign wr_enable  = wr && (reg_sel == ENABLE);
    assign wr_control = wr && (reg_sel == CONTROL);
    assign eoi        = wr_control && data[1];
    assign ack_take   = (state_q == StReq) && int_ack;

    // Register next-state. Edge detection is applied last so a new edge wins
    // over a same-cycle W1C or acknowledge clear of that bit.
    always_comb begin
        pending_d = pending_q;
        if (wr_pending) begin
            pending_d = pending_d & ~data[NUM_IRQ-1:0];
        end
        if (ack_take) begin
            pending_d = pending_d & ~vec_mask;
        end
        pending_d = pending_d | irq_edge;

        enable_d = wr_enable  ? data[NUM_IRQ-1:0] : enable_q;
        gen_d    = wr_control ? data[0]           : gen_q;
    end

    // FSM next-state. Entry into REQ looks at registered state so a source
    // edge takes two clocks to reach int_req; cancellation in REQ looks at the
    // next-state values so a clearing write drops int_req at its own edge.
    always_comb begin
        state_d      = state_q;
        vector_d     = vector_q;
        in_service_d = in_service_q;
        unique case (state_q)
            StIdle: begin
                if (gen_q && win_valid) begin
                    state_d  = StReq;
                    vector_d = win_idx;
                end
            end
            StReq: begin
                if (int_ack) begin
                    state_d      = StService;
                    in_service_d = 1'b1;
                end else if (!(|(pending_d & enable_d & vec_mask)) || !gen_d) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (eoi) begin
                    state_d      = StIdle;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            enable_q     <= '0;
            irq_q        <= '0;
            gen_q        <= 1'b0;
            in_service_q <= 1'b0;
            vector_q     <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            irq_q        <= irq;
            gen_q        <= gen_d;
            in_service_q <= in_service_d;
            vector_q     <= vector_d;
        end
    end

    // Reads come from registered state only, so a same-cycle write is not seen.
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            PENDING: rdata[NUM_IRQ-1:0] = pending_q;
            ENABLE:  rdata[NUM_IRQ-1:0] = enable_q;
            VECTOR:  rdata[VectorW-1:0] = vector_q;
            CONTROL: rdata[3:0]         = {state_q, in_service_q, gen_q};
            default: rdata = '0;
        endcase
    end

    assign data       = rd ? rdata : 'z;
    assign int_req    = (state_q == StReq);
    assign int_vector = vector_q;

endmodule
